// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width derivation and parameter validation.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package fifo_pkg;

    // Ceiling log2 for elaboration-time width derivation; clog2_f(1) == 0.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Pointer width: binary pointers that wrap naturally at DEPTH.
    function automatic int ptr_w_f(input int depth);
        return clog2_f(depth);
    endfunction

    // Count width: one extra bit so that the value DEPTH (full) is representable.
    function automatic int cnt_w_f(input int depth);
        return clog2_f(depth) + 1;
    endfunction

    function automatic bit is_pow2_f(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Validates the full parameter set, including both threshold ranges.
    function automatic bit params_ok_f(input int width, input int depth,
                                       input int af_thresh, input int ae_thresh);
        return (width >= 1) && (depth >= 4) && is_pow2_f(depth) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Bundle of the FIFO write/read handshake, data and status signals.
// Latency: none (wiring only).
// Backpressure: master watches full_o/empty_o; rejected requests raise overflow_o/underflow_o.
// Ports: master drives wr_en_i, wr_data_i, rd_en_i; slave (the FIFO) drives the rest.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CNT_W = cnt_w_f(DEPTH);

    logic             wr_en_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_en_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             rd_valid_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output wr_en_i, wr_data_i, rd_en_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, rd_en_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_mem_sp.sv
// WIDTH x DEPTH register array, one write port and one registered read port.
// Latency: read data appears one cycle after the read-enable edge; writes land at the edge.
// Backpressure: none; the caller only issues legal accesses.
// Ports: clk_i/rst_i, write (wr_en, wr_addr, wr_data), read (rd_en, rd_addr, rd_data).
module fifo_mem_sp
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = clog2_f(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset so this can map onto a vendor RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register clears on reset and holds between reads. On a same-address
    // read and write the old word is returned (read-before-write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, almost thresholds and error pulses.
// Latency: one cycle from an accepted read to rd_data_o/rd_valid_o; no write-to-read bypass.
// Backpressure: a write at full is accepted only with a concurrent read; rejected ops pulse overflow_o/underflow_o.
// Ports: clk_i, rst_i (sync, active-high), bus (sync_fifo_param_if.slave).
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = 28,
    parameter int AE_THRESH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sync_fifo_param_if.slave    bus
);
    localparam int PTR_W = ptr_w_f(DEPTH);
    localparam int CNT_W = cnt_w_f(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (!params_ok_f(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: illegal parameters (DEPTH must be a power of two >= 4, thresholds in range)");
    end

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic full;
    logic empty;
    logic rd_accept;
    logic wr_accept;

    // Flags decode the registered count only, so no input reaches an output combinationally.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // At full, a concurrent read frees the slot the write uses. At empty the read
    // is rejected even with a concurrent write (no bypass).
    assign rd_accept = bus.rd_en_i && !empty;
    assign wr_accept = bus.wr_en_i && (!full || rd_accept);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_accept && !rd_accept) begin
                count_q <= count_q + CNT_W'(1);
            end else if (rd_accept && !wr_accept) begin
                count_q <= count_q - CNT_W'(1);
            end
            rd_valid_q  <= rd_accept;
            overflow_q  <= bus.wr_en_i && !wr_accept;
            underflow_q <= bus.rd_en_i && !rd_accept;
        end
    end

    // Reset gates both ports so a concurrent request cannot touch memory or the read register.
    fifo_mem_sp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wr_en  (wr_accept && !rst_i),
        .wr_addr(wr_ptr_q),
        .wr_data(bus.wr_data_i),
        .rd_en  (rd_accept && !rst_i),
        .rd_addr(rd_ptr_q),
        .rd_data(bus.rd_data_o)
    );

    assign bus.rd_valid_o     = rd_valid_q;
    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.almost_full_o  = (count_q >= AF_C);
    assign bus.almost_empty_o = (count_q <= AE_C);
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.underflow_o    = underflow_q;
endmodule
